// File: rtl/cdp_dp_mul_arb_if.sv
// Handshake bundle between the CDP multiplier arbiter (master) and the shared
// signed multiplier stage (slave): operand request side plus product return side.
interface cdp_dp_mul_arb_if #(
  parameter int pINA_BW = 9,
  parameter int pINB_BW = 16
);
  logic                       mul_vld;
  logic                       mul_rdy;
  logic [pINA_BW-1:0]         mul_ina_pd;
  logic [pINB_BW-1:0]         mul_inb_pd;
  logic                       mul_unit_vld;
  logic                       mul_unit_rdy;
  logic [pINA_BW+pINB_BW-1:0] mul_unit_pd;

  modport master (
    output mul_vld, mul_ina_pd, mul_inb_pd, mul_unit_rdy,
    input  mul_rdy, mul_unit_vld, mul_unit_pd
  );

  modport slave (
    input  mul_vld, mul_ina_pd, mul_inb_pd, mul_unit_rdy,
    output mul_rdy, mul_unit_vld, mul_unit_pd
  );
endinterface

// File: rtl/cdp_dp_mul_arb.sv
// Round-robin arbiter sharing one signed multiplier among pREQ_NUM CDP lanes;
// a single tag register routes the in-flight product back to its owner.
module cdp_dp_mul_arb #(
  parameter int pREQ_NUM = 4,
  parameter int pINA_BW  = 9,
  parameter int pINB_BW  = 16,
  parameter int pCNT_BW  = 16
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rstn,
  input  logic [pREQ_NUM-1:0]           req_vld,
  output logic [pREQ_NUM-1:0]           req_rdy,
  input  logic [pREQ_NUM*pINA_BW-1:0]   req_ina_pd,
  input  logic [pREQ_NUM*pINB_BW-1:0]   req_inb_pd,
  cdp_dp_mul_arb_if.master              mul,
  output logic [pREQ_NUM-1:0]           rsp_vld,
  input  logic [pREQ_NUM-1:0]           rsp_rdy,
  output logic [pINA_BW+pINB_BW-1:0]    rsp_pd,
  input  logic                          op_cnt_clr,
  output logic [pCNT_BW-1:0]            op_cnt
);

  localparam int IDX_BW = (pREQ_NUM > 1) ? $clog2(pREQ_NUM) : 1;
  typedef logic [IDX_BW-1:0] idx_t;

  idx_t rr_ptr;
  idx_t lock_idx;
  idx_t tag;
  logic lock;

  idx_t pick;
  logic found;
  idx_t grant;
  logic gnt_vld;
  logic mul_vld;
  logic issue;
  logic stall;

  // NOTE: combinational blocks assign every output a default before any
  // conditional logic, so no path leaves a value held and no latch is inferred.
  always_comb begin
    int   idx;
    idx_t cand;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < pREQ_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= pREQ_NUM) idx = idx - pREQ_NUM;
      cand = idx_t'(idx);
      if (!found && req_vld[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // A stalled offer keeps its grant: the multiplier may already have latched it.
  assign grant   = lock ? lock_idx : pick;
  assign gnt_vld = lock | found;
  assign mul_vld = gnt_vld & req_vld[grant];
  assign issue   = mul_vld & mul.mul_rdy;
  assign stall   = mul_vld & ~mul.mul_rdy;

  assign mul.mul_vld    = mul_vld;
  assign mul.mul_ina_pd = gnt_vld ? req_ina_pd[int'(grant)*pINA_BW +: pINA_BW] : '0;
  assign mul.mul_inb_pd = gnt_vld ? req_inb_pd[int'(grant)*pINB_BW +: pINB_BW] : '0;

  always_comb begin
    req_rdy = '0;
    if (mul_vld) req_rdy[grant] = mul.mul_rdy;
  end

  always_comb begin
    rsp_vld      = '0;
    rsp_vld[tag] = mul.mul_unit_vld;
  end

  assign mul.mul_unit_rdy = rsp_rdy[tag];
  assign rsp_pd           = mul.mul_unit_pd;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      tag      <= '0;
    end else if (stall) begin
      lock     <= 1'b1;
      lock_idx <= grant;
    end else if (issue) begin
      lock   <= 1'b0;
      rr_ptr <= (int'(grant) == pREQ_NUM - 1) ? '0 : grant + 1'b1;
      tag    <= grant;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_cnt <= '0;
    end else if (op_cnt_clr) begin
      op_cnt <= '0;
    end else if ((rsp_vld & rsp_rdy) != '0) begin
      op_cnt <= op_cnt + 1'b1;
    end
  end

  lock_hold_a: assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    lock |-> req_vld[lock_idx]
  ) else $error("cdp_dp_mul_arb: locked requester dropped req_vld");

endmodule
